// File: rtl/status_vector_arbiter.sv
// status_vector_arbiter: round-robin push front-end and gated pull path for a
// shared 1-bit status FIFO. It tracks occupancy locally so a push is never
// issued into a full vector.
module status_vector_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AFULL_TH = 28
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ-1:0]             value_i,
  output logic [N_REQ-1:0]             ack_o,
  output logic                         svv_push_o,
  output logic                         svv_value_o,
  input  logic                         svv_full_i,
  input  logic                         svv_valid_i,
  input  logic                         svv_value_i,
  output logic                         svv_pull_o,
  input  logic                         cons_pull_i,
  output logic                         cons_valid_o,
  output logic                         cons_value_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         afull_o,
  output logic                         err_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [N_REQ-1:0]   ack_q;
  logic               push_q;
  logic               value_q;
  logic               err_q;
  logic [CNT_W-1:0]   count_q;

  logic [PTR_W-1:0]   win_idx_c;
  logic               win_vld_c;
  logic               grant_c;
  logic [PTR_W-1:0]   next_ptr_c;
  int unsigned        idx_c;

  // Round-robin search: first set request at or after rr_ptr, wrapping.
  always_comb begin
    win_vld_c = 1'b0;
    win_idx_c = '0;
    idx_c     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx_c = (32'(rr_ptr_q) + i) % N_REQ;
      if (!win_vld_c && req_i[PTR_W'(idx_c)]) begin
        win_vld_c = 1'b1;
        win_idx_c = PTR_W'(idx_c);
      end
    end
  end

  // Grants only use the registered count, so a same-cycle pull cannot free a slot.
  assign grant_c    = (state_q == IDLE) && win_vld_c &&
                      (count_q < CNT_W'(DEPTH)) && !svv_full_i;
  assign next_ptr_c = PTR_W'((32'(win_idx_c) + 32'd1) % N_REQ);

  // Push FSM: IDLE latches a winner, ISSUE drives the push and ack for one cycle.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      ack_q    <= '0;
      push_q   <= 1'b0;
      value_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      push_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_c) begin
            state_q  <= ISSUE;
            rr_ptr_q <= next_ptr_c;
            ack_q    <= N_REQ'(1) << win_idx_c;
            push_q   <= 1'b1;
            value_q  <= value_i[win_idx_c];
          end
        end
        ISSUE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pull is combinational; the local count guards against a stale valid.
  assign svv_pull_o = cons_pull_i & svv_valid_i & (count_q != '0);

  // Occupancy: push and pull in the same cycle cancel.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      count_q <= '0;
    end else begin
      case ({push_q, svv_pull_o})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flag for a consumer pull against an empty vector.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      err_q <= 1'b0;
    end else if (cons_pull_i && !svv_valid_i) begin
      err_q <= 1'b1;
    end
  end

  assign ack_o        = ack_q;
  assign svv_push_o   = push_q;
  assign svv_value_o  = value_q;
  assign cons_valid_o = svv_valid_i;
  assign cons_value_o = svv_value_i;
  assign count_o      = count_q;
  assign afull_o      = (count_q >= CNT_W'(AFULL_TH));
  assign err_o        = err_q;

endmodule
